// File: rtl/multi_word_adder_ctrl_pkg.sv
// Shared constants and types for the word-serial wide adder.
// Holds the word width, the FSM state encoding and the counter width helper.
package multi_word_adder_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multi_word_adder_ctrl_if.sv
// Operand/result handshake bundle for the word-serial wide adder.
// master drives operands and out_ready; slave is the sequencer.
interface multi_word_adder_ctrl_if #(
  parameter int WORDS = 4
);
  import multi_word_adder_ctrl_pkg::*;

  localparam int W = WORDS * WORD_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;

  modport master (
    output in_valid, op_sub, c_in, a, b, out_ready,
    input  in_ready, out_valid, result, c_out, overflow
  );

  modport slave (
    input  in_valid, op_sub, c_in, a, b, out_ready,
    output in_ready, out_valid, result, c_out, overflow
  );

endinterface

// File: rtl/multi_word_adder_ctrl_rca.sv
// 32-bit ripple carry adder shared across all words of a wide operation.
// Bit-serial carry chain, purely combinational.
module RippelCarryAdder
  import multi_word_adder_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              c_i,
  output logic [WORD_W-1:0] s_o,
  output logic              c_o
);

  logic [WORD_W:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < WORD_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[WORD_W];
  end

endmodule

// File: rtl/multi_word_adder_ctrl.sv
// Word-serial WORDS x 32-bit add/subtract sequencer around one shared
// ripple adder; LS word first, carry registered between words.
module multi_word_adder_ctrl
  import multi_word_adder_ctrl_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_word_adder_ctrl_if.slave bus
);

  localparam int W   = WORDS * WORD_W;
  localparam int CW  = cnt_w(WORDS);
  localparam int MSB = WORD_W - 1;

  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [WORD_W-1:0] a_w;
  logic [WORD_W-1:0] b_w;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              co;

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_w = a_q[i*WORD_W +: WORD_W];
        b_w = b_q[i*WORD_W +: WORD_W];
      end
    end
    b_eff = sub_q ? ~b_w : b_w;
  end

  RippelCarryAdder u_rca (
    .a_i (a_w),
    .b_i (b_eff),
    .c_i (carry_q),
    .s_o (sum),
    .c_o (co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.op_sub;
          // subtraction is a + ~b + 1, so the borrow-in enters inverted
          carry_d = bus.c_in ^ bus.op_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (cnt_q == CW'(i)) begin
            res_d[i*WORD_W +: WORD_W] = sum;
          end
        end
        carry_d = co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = sub_q ? ~co : co;
          ovf_d   = (a_w[MSB] == b_eff[MSB]) &&
                    (sum[MSB] != a_w[MSB]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.c_out     = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_multi_word_adder_ctrl.sv
// Directed bench for the word-serial wide adder with a result scoreboard.
// A full-width reference model supplies the expected results.
module tb_multi_word_adder_ctrl;
  import multi_word_adder_ctrl_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = WORDS * WORD_W;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_word_adder_ctrl_if #(.WORDS(WORDS)) bus ();

  multi_word_adder_ctrl #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         sbq[$];
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] last_res;
  logic         last_co;
  logic         last_ov;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic sub, input logic cin,
                                 input logic [W-1:0] aa,
                                 input logic [W-1:0] bb);
    exp_t         m;
    logic [W-1:0] be;
    logic [W:0]   s;
    be    = sub ? ~bb : bb;
    s     = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, cin ^ sub};
    m.res = s[W-1:0];
    m.co  = sub ? ~s[W] : s[W];
    m.ov  = (aa[W-1] == be[W-1]) && (s[W-1] != aa[W-1]);
    return m;
  endfunction

  task automatic accept(input logic sub, input logic cin,
                        input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input bit push);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", W'(n < 20), W'(1));
    bus.in_valid = 1'b1;
    bus.op_sub   = sub;
    bus.c_in     = cin;
    bus.a        = aa;
    bus.b        = bb;
    if (push) sbq.push_back(model(sub, cin, aa, bb));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(WORDS));
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    last_res = bus.result;
    last_co  = bus.c_out;
    last_ov  = bus.overflow;
    if (sbq.size() == 0) begin
      checks++;
      $error("FAIL %s observed=output expected=none queued", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_result"}, bus.result, e.res);
      chk({tag, "_c_out"}, W'(bus.c_out), W'(e.co));
      chk({tag, "_overflow"}, W'(bus.overflow), W'(e.ov));
    end
  endtask

  task automatic run_op(input string tag, input logic sub,
                        input logic cin, input logic [W-1:0] aa,
                        input logic [W-1:0] bb);
    accept(sub, cin, aa, bb, 1'b1);
    wait_out(tag);
    pop_cmp(tag);
    @(posedge clk); #1;
    chk({tag, "_back_idle"}, W'(bus.in_ready), W'(1));
    chk({tag, "_out_drop"}, W'(bus.out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] hold_res;
    logic         hold_co;
    ones          = '1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.c_in      = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_result", bus.result, '0);
    chk("rst_c_out", W'(bus.c_out), W'(0));
    chk("rst_overflow", W'(bus.overflow), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_wrap", 1'b0, 1'b0, ones, W'(1));
    chk("add_wrap_const", last_res, '0);
    chk("add_wrap_cout", W'(last_co), W'(1));

    run_op("sub_0m1", 1'b1, 1'b0, '0, W'(1));
    chk("sub_0m1_const", last_res, ones);
    chk("sub_0m1_borrow", W'(last_co), W'(1));

    run_op("sub_5m3", 1'b1, 1'b0, W'(5), W'(3));
    chk("sub_5m3_const", last_res, W'(2));
    chk("sub_5m3_borrow", W'(last_co), W'(0));

    run_op("add_ovf", 1'b0, 1'b0, {1'b0, {(W-1){1'b1}}}, W'(1));
    chk("add_ovf_const", last_res, {1'b1, {(W-1){1'b0}}});
    chk("add_ovf_flag", W'(last_ov), W'(1));

    run_op("add_cin", 1'b0, 1'b1, '0, '0);
    chk("add_cin_const", last_res, W'(1));

    run_op("xword", 1'b0, 1'b0, W'(32'hFFFF_FFFF), W'(1));
    chk("xword_const", last_res, W'(64'h1_0000_0000));

    run_op("sub_cin", 1'b1, 1'b1, W'(100), W'(40));

    // backpressure: result must hold while a new request waits
    bus.out_ready = 1'b0;
    accept(1'b0, 1'b0, W'(100), W'(200), 1'b1);
    wait_out("bp");
    hold_res     = bus.result;
    hold_co      = bus.c_out;
    bus.in_valid = 1'b1;
    bus.op_sub   = 1'b0;
    bus.c_in     = 1'b0;
    bus.a        = W'(7);
    bus.b        = W'(8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", W'(bus.out_valid), W'(1));
      chk("bp_result_hold", bus.result, hold_res);
      chk("bp_cout_hold", W'(bus.c_out), W'(hold_co));
      chk("bp_in_ready_low", W'(bus.in_ready), W'(0));
    end
    pop_cmp("bp");
    chk("bp_const", last_res, W'(300));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", W'(bus.in_ready), W'(1));
    chk("bp_drop", W'(bus.out_valid), W'(0));
    sbq.push_back(model(1'b0, 1'b0, W'(7), W'(8)));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_new_taken", W'(bus.in_ready), W'(0));
    wait_out("bp_new");
    pop_cmp("bp_new");
    chk("bp_new_const", last_res, W'(15));
    @(posedge clk); #1;

    // reset while word 2 is being processed
    accept(1'b0, 1'b0, ones, ones, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_in_ready", W'(bus.in_ready), W'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_ready", W'(bus.in_ready), W'(1));
    chk("mid_rst_result", bus.result, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_hold_valid", W'(bus.out_valid), W'(0));
    run_op("add_10_20", 1'b0, 1'b0, W'(10), W'(20));
    chk("add_10_20_const", last_res, W'(30));

    chk("sb_empty", W'(sbq.size()), W'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
